// File: rtl/arkanoid_i2s_tx.sv
// arkanoid_i2s_tx
// ---------------
// Sink end of the Arkanoid sound path. Filtered YM2149 samples arrive as a
// strobed 16-bit signed stream (187.5 kHz in the 12 MHz sound clock domain).
// Each group of 2^DECIM_LOG2 samples is boxcar-averaged, and the result is
// sent out as mono-duplicated 16-bit I2S (left = right). With the default
// parameters the frame rate is 12 MHz / 256 = 46.875 kHz.
//
// Ports
//   clk          sound clock (12 MHz)
//   reset        synchronous, active-high; aborts any frame in progress
//   in           signed input sample
//   in_valid     one-cycle strobe qualifying in
//   mute         when high, the next loaded frame carries 0
//   i2s_bclk     bit clock (period BCLK_DIV clk cycles)
//   i2s_lrck     word select, 0 = left, 1 = right
//   i2s_data     serial data, MSB first, one bclk after the lrck change
//   frame_start  one-cycle pulse marking the frame-load cycle
//
// All serial outputs are registered. They change on the clock edge at which
// the bit-clock divider sits at 0, so data and word select always move on
// the falling edge of i2s_bclk.

module arkanoid_i2s_tx #(
    parameter int BCLK_DIV   = 8,
    parameter int DECIM_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] in,
    input  logic               in_valid,
    input  logic               mute,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_data,
    output logic               frame_start
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int ACC_W = 16 + DECIM_LOG2 + 1;
    localparam int CNT_W = DECIM_LOG2 + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << DECIM_LOG2);

    // Timing state
    logic [DIV_W-1:0]        div_reg,   div_next;
    logic [4:0]              slot_reg,  slot_next;

    // Averager state
    logic signed [ACC_W-1:0] acc_reg,   acc_next;
    logic [CNT_W-1:0]        cnt_reg,   cnt_next;
    logic [15:0]             held_reg,  held_next;

    // Frame word {L, R} currently being serialised
    logic [31:0]             word_reg,  word_next;

    // Registered outputs
    logic                    bclk_reg,  bclk_next;
    logic                    lrck_reg,  lrck_next;
    logic                    data_reg,  data_next;
    logic                    fs_reg,    fs_next;

    logic                    is_load;
    logic                    is_bit_edge;
    logic                    window_full;
    logic signed [ACC_W-1:0] in_ext;
    logic [15:0]             sample_avg;
    logic [15:0]             sample_sel;
    logic [31:0]             word_load;
    logic [4:0]              bit_idx;

    // Mono duplication: both channel halves carry the selected sample.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign word_load[gi*16 +: 16] = sample_sel;
        end
    endgenerate

    always_comb begin
        is_load     = (div_reg == '0) && (slot_reg == '0);
        is_bit_edge = (div_reg == '0);
        window_full = (cnt_reg == CNT_FULL);
        in_ext      = {{(ACC_W-16){in[15]}}, in};

        // Arithmetic shift rounds toward -inf; the mean of 16-bit values
        // always fits back into 16 bits.
        sample_avg  = 16'(acc_reg >>> DECIM_LOG2);

        sample_sel = held_reg;
        if (mute) begin
            sample_sel = '0;
        end else if (window_full) begin
            sample_sel = sample_avg;
        end

        // Bit clock divider and slot counter
        div_next  = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        slot_next = (div_reg == DIV_LAST) ? slot_reg + 5'd1 : slot_reg;

        // Slot s sends W[32-s]; at slot 0 this wraps to bit 0 of the word
        // still held from the previous frame (I2S one-bit delay).
        bit_idx   = 5'd0 - slot_reg;

        bclk_next = (div_reg >= DIV_HALF);
        lrck_next = is_bit_edge ? slot_reg[4] : lrck_reg;
        data_next = is_bit_edge ? word_reg[bit_idx] : data_reg;
        fs_next   = is_load;

        word_next = is_load ? word_load : word_reg;

        // Held sample only follows real averages, never a muted zero or a
        // partial window.
        held_next = held_reg;
        if (is_load && !mute && window_full) begin
            held_next = sample_avg;
        end

        // Every load closes the window. A strobe on the load cycle opens the
        // new window instead of joining the closing one. Strobes beyond a
        // full window are dropped.
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        if (is_load) begin
            acc_next = in_valid ? in_ext : '0;
            cnt_next = in_valid ? CNT_W'(1) : '0;
        end else if (in_valid && !window_full) begin
            acc_next = acc_reg + in_ext;
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg  <= '0;
            slot_reg <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            held_reg <= '0;
            word_reg <= '0;
            bclk_reg <= 1'b0;
            lrck_reg <= 1'b0;
            data_reg <= 1'b0;
            fs_reg   <= 1'b0;
        end else begin
            div_reg  <= div_next;
            slot_reg <= slot_next;
            acc_reg  <= acc_next;
            cnt_reg  <= cnt_next;
            held_reg <= held_next;
            word_reg <= word_next;
            bclk_reg <= bclk_next;
            lrck_reg <= lrck_next;
            data_reg <= data_next;
            fs_reg   <= fs_next;
        end
    end

    assign i2s_bclk    = bclk_reg;
    assign i2s_lrck    = lrck_reg;
    assign i2s_data    = data_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_arkanoid_i2s_tx.sv
// Testbench for arkanoid_i2s_tx (default parameters: 256-clock frames).
// Inputs are driven on the falling clock edge; outputs are sampled on the
// following falling edge, i.e. half a cycle after the active edge. The
// reference model works per frame: it keeps the list of strobed samples of
// the open window and decides each frame's sample from it with plain
// arithmetic. A deserialiser rebuilds every transmitted word and compares
// it with the model's word for that frame.

module tb_arkanoid_i2s_tx;

    localparam int FRAME = 256;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        mute;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        frame_start;

    arkanoid_i2s_tx dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_data),
        .in_valid    (in_valid),
        .mute        (mute),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_data    (i2s_data),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state
    int          pos = -1;           // clock edges since reset release, -1 in reset
    logic [15:0] window[$];          // samples strobed in the open window
    logic [15:0] held_m;
    logic [31:0] exp_q[$];           // expected word per frame, oldest first
    bit          deser_live;         // a full frame has been collected since reset
    logic [31:0] bits_acc;           // received W[31:1] of the frame in flight
    int          frame_no = 0;

    logic [15:0] sq[$];              // samples to strobe in the next frame

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advances the model across one clock edge with the given inputs.
    task automatic model_edge(input logic r, input logic v, input logic [15:0] d, input logic m);
        int          fp;
        int          sum;
        int          q;
        logic [15:0] s;
        if (r) begin
            pos        = -1;
            held_m     = '0;
            deser_live = 0;
            window.delete();
            exp_q.delete();
        end else begin
            pos = pos + 1;
            fp  = pos % FRAME;
            if (fp == 0) begin
                if (m) begin
                    s = '0;
                end else if (window.size() >= 4) begin
                    sum = 0;
                    for (int i = 0; i < 4; i++) sum += $signed(window[i]);
                    q = sum / 4;
                    if (sum < 0 && (sum % 4) != 0) q -= 1;   // floor division
                    s      = q[15:0];
                    held_m = s;
                end else begin
                    s = held_m;
                end
                exp_q.push_back({s, s});
                window.delete();
            end
            if (v) window.push_back(d);
        end
    endtask

    task automatic check_outputs();
        int          fp;
        int          slot;
        logic [31:0] w;
        logic [31:0] e;
        if (pos < 0) begin
            check("rst_bclk",  i2s_bclk,    0);
            check("rst_lrck",  i2s_lrck,    0);
            check("rst_data",  i2s_data,    0);
            check("rst_fs",    frame_start, 0);
        end else begin
            fp = pos % FRAME;
            check("frame_start", frame_start, fp == 0);
            check("bclk",        i2s_bclk,    (fp % 8) >= 4);
            check("lrck",        i2s_lrck,    fp >= 128);
            if (fp % 8 == 0) begin
                slot = fp / 8;
                if (slot == 0) begin
                    if (deser_live) begin
                        w = {bits_acc[31:1], i2s_data};
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            $display("frame %0d: L=%04h R=%04h expected %04h", frame_no,
                                     w[31:16], w[15:0], e[15:0]);
                            check("word_L", w[31:16], e[31:16]);
                            check("word_R", w[15:0],  e[15:0]);
                        end else begin
                            check("exp_queue_empty", 1, 0);
                        end
                        frame_no++;
                    end else begin
                        check("lsb_after_reset", i2s_data, 0);
                    end
                    deser_live = 1;
                end else begin
                    bits_acc[32 - slot] = i2s_data;
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [15:0] d, input logic m);
        reset    = r;
        in_valid = v;
        in_data  = d;
        mute     = m;
        model_edge(r, v, d, m);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // One full frame, starting on its load cycle. Samples in sq are strobed at
    // first_pos, first_pos+gap, ...; mute is m0 before cycle mute_from, m1 after.
    task automatic run_frame(input int first_pos, input int gap, input logic m0,
                             input int mute_from, input logic m1);
        int k;
        k = 0;
        for (int c = 0; c < FRAME; c++) begin
            logic        v;
            logic [15:0] d;
            v = 1'b0;
            d = 16'($urandom);
            if (k < sq.size() && c == first_pos + gap * k) begin
                v = 1'b1;
                d = sq[k];
                k++;
            end
            tick(1'b0, v, d, (c >= mute_from) ? m1 : m0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        mute     = 1'b0;

        repeat (10) tick(1'b1, 1'b0, 16'h0, 1'b0);

        // Idle first frame, then a constant stream every 64 cycles
        sq = {};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};
        repeat (3) run_frame(20, 64, 1'b0, FRAME, 1'b0);

        // Averaging, including negative rounding toward -inf
        sq = '{16'd100, 16'd200, 16'd300, 16'd400};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = '{16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);

        // Starvation repeats the held average
        sq = '{16'd100, 16'd200, 16'd300, 16'd400};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = {};
        repeat (3) run_frame(20, 40, 1'b0, FRAME, 1'b0);

        // Overfull window, then a partial window
        sq = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd99, 16'd99};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = '{16'd5, 16'd6};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = {};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);

        // Strobe coincident with the load cycle opens the new window
        sq = '{16'd50, 16'd50, 16'd50, 16'd50};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = '{16'd8, 16'd8, 16'd8, 16'd8};
        run_frame(0, 40, 1'b0, FRAME, 1'b0);
        sq = {};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);

        // Mute raised mid-frame, dropped just after the next load
        sq = '{16'd77, 16'd77, 16'd77, 16'd77};
        run_frame(20, 40, 1'b0, 128, 1'b1);
        sq = {};
        run_frame(20, 40, 1'b1, 8, 1'b0);
        run_frame(20, 40, 1'b0, FRAME, 1'b0);

        // Random windows
        for (int f = 0; f < 10; f++) begin
            int   n;
            logic m;
            n  = $urandom_range(0, 6);
            m  = ($urandom_range(0, 4) == 0);
            sq = {};
            for (int i = 0; i < n; i++) sq.push_back(16'($urandom));
            run_frame($urandom_range(0, 30), 37, m, FRAME, m);
        end

        // Reset in slot 20 aborts the frame
        for (int c = 0; c < 20 * 8 + 3; c++) tick(1'b0, 1'b0, 16'($urandom), 1'b0);
        repeat (3) tick(1'b1, 1'b0, 16'h0, 1'b0);
        sq = '{16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);
        sq = {};
        run_frame(20, 40, 1'b0, FRAME, 1'b0);

        // Final load completes the last word
        tick(1'b0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
